// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: state codes, decoder flow
// classes, PC source selects and the bundle of per-cycle control strobes.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_INTR  = 2'b11
    } pc_state_e;

    localparam logic [3:0] FLOW_SEQ  = 4'd0;
    localparam logic [3:0] FLOW_BR   = 4'd1;
    localparam logic [3:0] FLOW_BRC  = 4'd2;
    localparam logic [3:0] FLOW_CALL = 4'd3;
    localparam logic [3:0] FLOW_RET  = 4'd4;
    localparam logic [3:0] FLOW_RETI = 4'd5;
    localparam logic [3:0] FLOW_SEI  = 4'd6;
    localparam logic [3:0] FLOW_CLI  = 4'd7;

    localparam logic [1:0] MUX_IMM  = 2'b00;
    localparam logic [1:0] MUX_STK  = 2'b01;
    localparam logic [1:0] MUX_VEC  = 2'b10;
    localparam logic [1:0] MUX_ZERO = 2'b11;

    typedef struct packed {
        logic       pc_rst;
        logic       pc_ld;
        logic       pc_inc;
        logic [1:0] pc_mux_sel;
        logic       sp_incr;
        logic       sp_decr;
        logic       scr_we;
        logic       scr_data_sel;
        logic       flg_shad_ld;
        logic       flg_restore;
    } ctrl_t;

    // Codes 8-15 are undefined classes and behave like a plain sequential op.
    function automatic logic [3:0] flow_norm(input logic [3:0] f);
        return f[3] ? FLOW_SEQ : f;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/datapath-facing bundle of the sequencer: flow inputs and the
// control strobes it produces, plus debug/status outputs.
interface pc_sequencer_if #(
    parameter int STK_DEPTH = 16
);
    localparam int DEPTH_W = $clog2(STK_DEPTH + 1);

    logic [3:0]         flow;
    logic               cond_met;
    logic               intr;

    logic               pc_rst;
    logic               pc_ld;
    logic               pc_inc;
    logic [1:0]         pc_mux_sel;
    logic               sp_incr;
    logic               sp_decr;
    logic               scr_we;
    logic               scr_data_sel;
    logic               flg_shad_ld;
    logic               flg_restore;
    logic               i_en;
    logic               stk_err;
    logic [1:0]         state;
    logic [DEPTH_W-1:0] stk_depth;

    modport master (
        input  flow, cond_met, intr,
        output pc_rst, pc_ld, pc_inc, pc_mux_sel, sp_incr, sp_decr,
               scr_we, scr_data_sel, flg_shad_ld, flg_restore,
               i_en, stk_err, state, stk_depth
    );

    modport slave (
        output flow, cond_met, intr,
        input  pc_rst, pc_ld, pc_inc, pc_mux_sel, sp_incr, sp_decr,
               scr_we, scr_data_sel, flg_shad_ld, flg_restore,
               i_en, stk_err, state, stk_depth
    );

endinterface

// File: rtl/stk_depth_ctr.sv
// Saturating call/interrupt nesting counter with a sticky over/underflow flag.
module stk_depth_ctr #(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          err
);
    localparam logic [CW-1:0] MAX_COUNT = CW'(DEPTH);

    logic [CW-1:0] count_reg, count_next;
    logic          err_reg, err_next;

    always_comb begin
        count_next = count_reg;
        err_next   = err_reg;
        if (inc && !dec) begin
            if (count_reg == MAX_COUNT) begin
                err_next = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_reg == '0) begin
                err_next = 1'b1;
            end else begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    assign count = count_reg;
    assign err   = err_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-cycle sequencer: INIT/FETCH/EXEC/INTR control FSM driving the PC,
// stack pointer, scratch RAM and flag shadow, with interrupt enable and pending logic.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int STK_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);
    localparam int DEPTH_W = $clog2(STK_DEPTH + 1);

    localparam logic [1:0] S_INIT  = ST_INIT;
    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_EXEC  = ST_EXEC;
    localparam logic [1:0] S_INTR  = ST_INTR;

    logic [1:0]         state_reg, state_next;
    logic               i_en_reg, i_en_next;
    logic               pending_reg, pending_next;
    logic [3:0]         flow;
    logic               take_intr;
    logic               push;
    logic               pop;
    ctrl_t              ctrl;
    logic [DEPTH_W-1:0] depth_count;

    assign flow = flow_norm(bus.flow);

    // The request seen this cycle counts as well as a latched one, so a
    // one-cycle pulse during EXEC is still taken.
    assign take_intr = (state_reg == S_EXEC) && i_en_reg && (pending_reg || bus.intr);

    always_comb begin
        ctrl = '0;
        case (state_reg)
            S_INIT:  ctrl.pc_rst = 1'b1;
            S_FETCH: ctrl.pc_inc = 1'b1;
            S_EXEC: begin
                case (flow)
                    FLOW_BR: begin
                        ctrl.pc_ld      = 1'b1;
                        ctrl.pc_mux_sel = MUX_IMM;
                    end
                    FLOW_BRC: begin
                        ctrl.pc_ld      = bus.cond_met;
                        ctrl.pc_mux_sel = MUX_IMM;
                    end
                    FLOW_CALL: begin
                        ctrl.pc_ld        = 1'b1;
                        ctrl.pc_mux_sel   = MUX_IMM;
                        ctrl.sp_decr      = 1'b1;
                        ctrl.scr_we       = 1'b1;
                        ctrl.scr_data_sel = 1'b1;
                    end
                    FLOW_RET, FLOW_RETI: begin
                        ctrl.pc_ld       = 1'b1;
                        ctrl.pc_mux_sel  = MUX_STK;
                        ctrl.sp_incr     = 1'b1;
                        ctrl.flg_restore = (flow == FLOW_RETI);
                    end
                    default: ;
                endcase
            end
            S_INTR: begin
                ctrl.pc_ld        = 1'b1;
                ctrl.pc_mux_sel   = MUX_VEC;
                ctrl.sp_decr      = 1'b1;
                ctrl.scr_we       = 1'b1;
                ctrl.scr_data_sel = 1'b1;
                ctrl.flg_shad_ld  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = S_INIT;
        case (state_reg)
            S_INIT:  state_next = S_FETCH;
            S_FETCH: state_next = S_EXEC;
            S_EXEC:  state_next = take_intr ? S_INTR : S_FETCH;
            S_INTR:  state_next = S_FETCH;
            default: state_next = S_INIT;
        endcase
    end

    always_comb begin
        i_en_next = i_en_reg;
        if (state_reg == S_EXEC) begin
            if (flow == FLOW_SEI || flow == FLOW_RETI) begin
                i_en_next = 1'b1;
            end else if (flow == FLOW_CLI) begin
                i_en_next = 1'b0;
            end
        end else if (state_reg == S_INTR) begin
            i_en_next = 1'b0;
        end
    end

    // Acknowledge in INTR wins over a request arriving in that same cycle.
    assign pending_next = (state_reg == S_INTR) ? 1'b0 : (pending_reg | bus.intr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_INIT;
            i_en_reg    <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            i_en_reg    <= i_en_next;
            pending_reg <= pending_next;
        end
    end

    assign push = ((state_reg == S_EXEC) && (flow == FLOW_CALL)) || (state_reg == S_INTR);
    assign pop  = (state_reg == S_EXEC) && ((flow == FLOW_RET) || (flow == FLOW_RETI));

    stk_depth_ctr #(
        .DEPTH (STK_DEPTH)
    ) u_depth (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .dec   (pop),
        .count (depth_count),
        .err   (bus.stk_err)
    );

    assign bus.pc_rst       = ctrl.pc_rst;
    assign bus.pc_ld        = ctrl.pc_ld;
    assign bus.pc_inc       = ctrl.pc_inc;
    assign bus.pc_mux_sel   = ctrl.pc_mux_sel;
    assign bus.sp_incr      = ctrl.sp_incr;
    assign bus.sp_decr      = ctrl.sp_decr;
    assign bus.scr_we       = ctrl.scr_we;
    assign bus.scr_data_sel = ctrl.scr_data_sel;
    assign bus.flg_shad_ld  = ctrl.flg_shad_ld;
    assign bus.flg_restore  = ctrl.flg_restore;
    assign bus.i_en         = i_en_reg;
    assign bus.state        = state_reg;
    assign bus.stk_depth    = depth_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a cycle-level reference model pushes the
// expected output vector per cycle; a negedge monitor pops and compares.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic       pc_rst;
        logic       pc_ld;
        logic       pc_inc;
        logic [1:0] mux;
        logic       sp_incr;
        logic       sp_decr;
        logic       scr_we;
        logic       scr_data_sel;
        logic       flg_shad_ld;
        logic       flg_restore;
        logic       i_en;
        logic       stk_err;
        logic [1:0] state;
        logic [4:0] depth;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];

    // Reference model: phase 0 init, 1 fetch, 2 exec, 3 interrupt entry.
    int m_phase;
    bit m_ien;
    bit m_pend;
    bit m_err;
    int m_depth;

    pc_sequencer_if #(.STK_DEPTH(DEPTH)) bus();

    pc_sequencer #(.STK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t a;
        a.pc_rst       = bus.pc_rst;
        a.pc_ld        = bus.pc_ld;
        a.pc_inc       = bus.pc_inc;
        a.mux          = bus.pc_mux_sel;
        a.sp_incr      = bus.sp_incr;
        a.sp_decr      = bus.sp_decr;
        a.scr_we       = bus.scr_we;
        a.scr_data_sel = bus.scr_data_sel;
        a.flg_shad_ld  = bus.flg_shad_ld;
        a.flg_restore  = bus.flg_restore;
        a.i_en         = bus.i_en;
        a.stk_err      = bus.stk_err;
        a.state        = bus.state;
        a.depth        = bus.stk_depth;
        return a;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_ien   = 0;
        m_pend  = 0;
        m_err   = 0;
        m_depth = 0;
    endtask

    task automatic model_step(input logic [3:0] f_in, input logic cond, input logic irq, output obs_t e);
        int f;
        bit do_push, do_pop, go;
        f = (f_in > 4'd7) ? 0 : int'(f_in);
        e = '0;
        e.state   = 2'(m_phase);
        e.i_en    = m_ien;
        e.stk_err = m_err;
        e.depth   = 5'(m_depth);
        do_push = 0;
        do_pop  = 0;
        if (m_phase == 0) e.pc_rst = 1;
        if (m_phase == 1) e.pc_inc = 1;
        if (m_phase == 2) begin
            if (f == 1 || (f == 2 && cond)) e.pc_ld = 1;
            if (f == 3) begin
                e.pc_ld = 1; e.sp_decr = 1; e.scr_we = 1; e.scr_data_sel = 1; do_push = 1;
            end
            if (f == 4 || f == 5) begin
                e.pc_ld = 1; e.mux = 2'b01; e.sp_incr = 1; e.flg_restore = (f == 5); do_pop = 1;
            end
        end
        if (m_phase == 3) begin
            e.pc_ld = 1; e.mux = 2'b10; e.sp_decr = 1; e.scr_we = 1;
            e.scr_data_sel = 1; e.flg_shad_ld = 1; do_push = 1;
        end
        go = (m_phase == 2) && m_ien && (m_pend || irq);
        if (do_push) begin
            if (m_depth == DEPTH) m_err = 1; else m_depth++;
        end
        if (do_pop) begin
            if (m_depth == 0) m_err = 1; else m_depth--;
        end
        if (m_phase == 2 && (f == 5 || f == 6)) m_ien = 1;
        if (m_phase == 2 && f == 7) m_ien = 0;
        if (m_phase == 3) m_ien = 0;
        m_pend  = (m_phase == 3) ? 0 : (m_pend | irq);
        m_phase = (m_phase == 0) ? 1 : (m_phase == 1) ? 2 : (m_phase == 2) ? (go ? 3 : 1) : 1;
    endtask

    // One clock cycle: called at posedge+1, drives inputs and the expectation.
    task automatic cyc(input logic [3:0] f, input logic c, input logic irq);
        obs_t e;
        bus.flow     = f;
        bus.cond_met = c;
        bus.intr     = irq;
        model_step(f, c, irq, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] f, input logic c, input logic irq);
        for (int k = 0; k < 4 && m_phase != 2; k++) cyc(FLOW_SEQ, 1'b0, irq);
        cyc(f, c, irq);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.flow = '0; bus.cond_met = 1'b0; bus.intr = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_state", 32'(bus.state), 32'(2'b00));
        check("reset_pc_rst", 32'(bus.pc_rst), 32'(1'b1));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            check("cycle_outputs", 32'(observe()), 32'(e));
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.flow = '0; bus.cond_met = 1'b0; bus.intr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset release and plain sequential flow
        do_reset();
        repeat (6) cyc(FLOW_SEQ, 1'b0, 1'b0);

        // Conditional branch not taken, then taken
        instr(FLOW_BRC, 1'b0, 1'b0);
        instr(FLOW_BRC, 1'b1, 1'b0);
        instr(FLOW_BR,  1'b0, 1'b0);

        // SEI then a single-cycle request during FETCH
        instr(FLOW_SEI, 1'b0, 1'b0);
        cyc(FLOW_SEQ, 1'b0, 1'b1);
        cyc(FLOW_SEQ, 1'b0, 1'b0);
        check("req036_state_intr", 32'(bus.state), 32'(2'b11));
        check("req036_mux_vec", 32'(bus.pc_mux_sel), 32'(2'b10));
        cyc(FLOW_SEQ, 1'b0, 1'b0);
        check("req036_ien_cleared", 32'(bus.i_en), 32'(1'b0));
        instr(FLOW_SEI, 1'b0, 1'b0);
        instr(FLOW_SEQ, 1'b0, 1'b0);
        check("req036_pending_cleared", 32'(bus.state), 32'(2'b01));

        // Request held while disabled, then SEI
        instr(FLOW_CLI, 1'b0, 1'b0);
        repeat (5) instr(FLOW_SEQ, 1'b0, 1'b1);
        instr(FLOW_SEI, 1'b0, 1'b1);
        check("req037_not_after_sei", 32'(bus.state), 32'(2'b01));
        instr(FLOW_SEQ, 1'b0, 1'b1);
        check("req037_after_next_exec", 32'(bus.state), 32'(2'b11));
        cyc(FLOW_SEQ, 1'b0, 1'b0);
        instr(FLOW_RETI, 1'b0, 1'b0);

        // Nesting overflow after 17 calls, underflow on a lone return
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            instr(FLOW_CALL, 1'b0, 1'b0);
            if (n == 16) check("req038_no_err_at_16", 32'(bus.stk_err), 32'(1'b0));
        end
        check("req038_overflow", 32'(bus.stk_err), 32'(1'b1));
        instr(FLOW_RET, 1'b0, 1'b0);
        check("req038_err_sticky", 32'(bus.stk_err), 32'(1'b1));
        do_reset();
        check("reset_clears_err", 32'(bus.stk_err), 32'(1'b0));
        instr(FLOW_RET, 1'b0, 1'b0);
        check("req038_underflow", 32'(bus.stk_err), 32'(1'b1));

        // Randomized run
        do_reset();
        for (int n = 0; n < 500; n++) begin
            logic [3:0] f;
            f = 4'($urandom_range(0, 15));
            cyc(f, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset while in the interrupt state
        do_reset();
        instr(FLOW_SEI, 1'b0, 1'b0);
        for (int k = 0; k < 8 && m_phase != 3; k++) cyc(FLOW_SEQ, 1'b0, 1'b1);
        check("req039_in_intr", 32'(bus.state), 32'(2'b11));
        check("req039_ien_before", 32'(bus.i_en), 32'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("req039_async_state", 32'(bus.state), 32'(2'b00));
        check("req039_async_ien", 32'(bus.i_en), 32'(1'b0));
        check("req039_async_depth", 32'(bus.stk_depth), 32'(0));
        exp_q.delete();
        model_reset();
        bus.intr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr(FLOW_SEI, 1'b0, 1'b0);
        instr(FLOW_SEQ, 1'b0, 1'b0);
        check("req039_pending_cleared", 32'(bus.state), 32'(2'b01));
        instr(FLOW_SEQ, 1'b0, 1'b0);

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
